// File: rtl/morse_symbol_decoder_pkg.sv
// Shared definitions for the Morse symbol decoder.
//   state_t  : FSM encodings (IDLE, PRESS, GAP)
//   MAX_SYMS : symbols a single letter may hold before overflow
//   CODE_W   : width of the accumulated code
//   LEN_W    : width of the symbol count
package morse_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int MAX_SYMS = 5;
    localparam int CODE_W   = 5;
    localparam int LEN_W    = 3;

endpackage

// File: rtl/morse_symbol_decoder_if.sv
// Key-side inputs and symbol/letter outputs of the Morse symbol decoder.
//   tick, key                        : driven by the key conditioning side
//   sym_valid, sym_dash              : per-symbol result
//   code, len, err, letter_valid     : per-letter result
// Modports: master drives tick/key and observes results; slave is the decoder.
interface morse_symbol_decoder_if;
    import morse_defs::*;

    logic              tick;
    logic              key;
    logic              sym_valid;
    logic              sym_dash;
    logic [CODE_W-1:0] code;
    logic [LEN_W-1:0]  len;
    logic              letter_valid;
    logic              err;

    modport master (
        output tick, key,
        input  sym_valid, sym_dash, code, len, letter_valid, err
    );

    modport slave (
        input  tick, key,
        output sym_valid, sym_dash, code, len, letter_valid, err
    );

endinterface

// File: rtl/morse_symbol_decoder_sat_counter.sv
// Saturating up-counter used to time key presses and gaps.
//   clk, reset_n : clock and asynchronous active-low reset
//   clear        : synchronous clear, takes priority over en
//   en           : count enable; the count holds once it reaches all-ones
//   count        : current count
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (en && (count_reg != {CNT_W{1'b1}})) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/morse_symbol_decoder.sv
// Morse symbol decoder: times key presses and gaps in units of tick,
// classifies presses as dot/dash, accumulates up to MAX_SYMS symbols and
// emits the letter after a LETTER_GAP-tick release.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus (slave)  : tick/key in; sym_valid, sym_dash, code, len,
//                  letter_valid, err out (all registered)
module morse_symbol_decoder
    import morse_defs::*;
#(
    parameter int DOT_MAX    = 20,
    parameter int LETTER_GAP = 30,
    parameter int CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    morse_symbol_decoder_if.slave  bus
);

    localparam logic [CNT_W-1:0] DOT_MAX_C  = CNT_W'(DOT_MAX);
    // Count value at which one more gap tick closes the letter.
    localparam logic [CNT_W-1:0] GAP_LAST_C = CNT_W'(LETTER_GAP - 1);
    localparam logic [LEN_W-1:0] MAX_LEN_C  = LEN_W'(MAX_SYMS);

    state_t            state_reg, state_next;
    logic              sym_valid_reg, sym_valid_next;
    logic              sym_dash_reg, sym_dash_next;
    logic              letter_valid_reg, letter_valid_next;
    logic [CODE_W-1:0] code_reg, code_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic              err_reg, err_next;

    logic              cnt_clear;
    logic              cnt_en;
    logic [CNT_W-1:0]  cnt;
    logic              sym_fire;
    logic              is_dash;

    sat_counter #(.CNT_W(CNT_W)) u_dur_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .en      (cnt_en),
        .count   (cnt)
    );

    assign is_dash = (cnt > DOT_MAX_C);

    // FSM next state and counter control.
    always_comb begin
        state_next        = state_reg;
        cnt_clear         = 1'b0;
        cnt_en            = 1'b0;
        sym_fire          = 1'b0;
        letter_valid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.key) begin
                    cnt_clear  = 1'b1;
                    state_next = PRESS;
                end
            end
            PRESS: begin
                if (!bus.key) begin
                    // A tick in the release cycle is dropped: clear wins.
                    sym_fire   = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = GAP;
                end else begin
                    cnt_en = bus.tick;
                end
            end
            GAP: begin
                // A new press beats a coincident closing tick.
                if (bus.key) begin
                    cnt_clear  = 1'b1;
                    state_next = PRESS;
                end else if (bus.tick) begin
                    cnt_en = 1'b1;
                    if (cnt == GAP_LAST_C) begin
                        letter_valid_next = 1'b1;
                        cnt_clear         = 1'b1;
                        state_next        = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Symbol accumulation. The letter fields are cleared one cycle after
    // letter_valid is raised so they are held during the pulse; the FSM is
    // in IDLE then, so no symbol can collide with the clear.
    always_comb begin
        sym_valid_next = sym_fire;
        sym_dash_next  = sym_dash_reg;
        code_next      = code_reg;
        len_next       = len_reg;
        err_next       = err_reg;
        if (letter_valid_reg) begin
            code_next = '0;
            len_next  = '0;
            err_next  = 1'b0;
        end else if (sym_fire) begin
            sym_dash_next = is_dash;
            if (len_reg < MAX_LEN_C) begin
                code_next = {code_reg[CODE_W-2:0], is_dash};
                len_next  = len_reg + LEN_W'(1);
            end else begin
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            sym_valid_reg    <= 1'b0;
            sym_dash_reg     <= 1'b0;
            letter_valid_reg <= 1'b0;
            code_reg         <= '0;
            len_reg          <= '0;
            err_reg          <= 1'b0;
        end else begin
            state_reg        <= state_next;
            sym_valid_reg    <= sym_valid_next;
            sym_dash_reg     <= sym_dash_next;
            letter_valid_reg <= letter_valid_next;
            code_reg         <= code_next;
            len_reg          <= len_next;
            err_reg          <= err_next;
        end
    end

    assign bus.sym_valid    = sym_valid_reg;
    assign bus.sym_dash     = sym_dash_reg;
    assign bus.letter_valid = letter_valid_reg;
    assign bus.code         = code_reg;
    assign bus.len          = len_reg;
    assign bus.err          = err_reg;

endmodule
